// File: rtl/bcd_result_converter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_result_converter
// Function : Sequential double-dabble conversion of the ALU result word to
//            packed BCD digits plus a sign flag, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_result_converter #(
    parameter int DATA_WIDTH = 8,
    parameter int NDIG       = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*DATA_WIDTH-1:0]   data_i,
    input  logic                      signed_mode_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [4*NDIG-1:0]         bcd_o,
    output logic                      neg_o
);

    localparam int c_W     = 2 * DATA_WIDTH;
    localparam int c_BW    = 4 * NDIG;
    localparam int c_CNT_W = $clog2(c_W);

    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(c_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_W-1:0]     c_W_ONE    = c_W'(1);
    localparam logic [c_BW-1:0]    c_BW_ONE   = c_BW'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               state_q;
    logic [c_W-1:0]       mag_q;
    logic [c_BW-1:0]      scratch_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic                 neg_r_q;
    logic                 busy_q;
    logic                 done_q;
    logic [c_BW-1:0]      bcd_q;
    logic                 neg_q;

    logic                 w_neg_in;
    logic [c_W-1:0]       w_mag_in;
    logic [c_BW-1:0]      w_adj;
    logic [c_BW-1:0]      scratch_d;
    logic [c_W-1:0]       mag_d;

    assign w_neg_in = signed_mode_i & data_i[c_W-1];
    // Negating 0x8000-style minimum yields itself, which reads correctly as unsigned.
    assign w_mag_in = w_neg_in ? (~data_i + c_W_ONE) : data_i;

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        assign w_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                  (scratch_q[4*gi +: 4] + 4'd3) :
                                   scratch_q[4*gi +: 4];
    end

    assign scratch_d = (w_adj << 1) | (mag_q[c_W-1] ? c_BW_ONE : '0);
    assign mag_d     = mag_q << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            neg_r_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        neg_r_q   <= w_neg_in;
                        mag_q     <= w_mag_in;
                        scratch_q <= '0;
                        cnt_q     <= c_CNT_INIT;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch_q <= scratch_d;
                    mag_q     <= mag_d;
                    cnt_q     <= cnt_q - c_CNT_ONE;
                    if (cnt_q == '0) begin
                        bcd_q   <= scratch_d;
                        neg_q   <= neg_r_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;
    assign neg_o  = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_result_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_result_converter
// Function : Directed, self-checking bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_result_converter;

    localparam int          DW   = 8;
    localparam int          W    = 2 * DW;
    localparam int          ND   = 5;
    localparam int          BW   = 4 * ND;
    localparam int unsigned SPAN = 32'd65536;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  data  = '0;
    logic          sm    = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [BW-1:0] bcd;
    logic          neg;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit chk_en      = 1'b0;

    // reference model state
    int          m_left = 0;
    int unsigned m_mag  = 0;
    logic        m_sign = 1'b0;
    logic        m_done = 1'b0;
    logic        m_neg  = 1'b0;
    logic [BW-1:0] m_bcd = '0;

    bcd_result_converter #(.DATA_WIDTH(DW), .NDIG(ND)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_i       (data),
        .signed_mode_i(sm),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .bcd_o        (bcd),
        .neg_o        (neg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BW-1:0] to_bcd(input int unsigned v);
        logic [BW-1:0] r;
        int unsigned   p;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a conversion accepted at an edge delivers its result W edges later.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_bcd  = '0;
            m_neg  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd  = to_bcd(m_mag);
                    m_neg  = m_sign;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_sign = sm && data[W-1];
                m_mag  = m_sign ? SPAN - 32'(data) : 32'(data);
                m_left = W;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            check("bcd",  32'(bcd),  32'(m_bcd));
            check("neg",  32'(neg),  32'(m_neg));
            check("busy_and_done", 32'(busy & done), 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int busy_n, output int at_cyc, output bit ok);
        busy_n = 0;
        at_cyc = 0;
        ok     = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                ok     = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done, expected done within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    task automatic run(input logic [W-1:0] d, input logic s,
                       input logic [BW-1:0] eb, input logic en);
        int bn, c;
        bit ok;
        data  = d;
        sm    = s;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(bn, c, ok);
        if (ok) begin
            check("lit_bcd", 32'(bcd), 32'(eb));
            check("lit_neg", 32'(neg), 32'(en));
            check("busy_len", 32'(bn), 32'(W));
        end
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bn, c1, c2, c3, n;
        bit ok;

        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_bcd",  32'(bcd),  32'h0);
        check("rst_neg",  32'(neg),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        count_dones(20, n);
        check("idle_no_done", 32'(n), 32'd0);
        check("idle_bcd", 32'(bcd), 32'h0);
        tick(1);

        run(16'h00FF, 1'b0, 20'h00255, 1'b0);
        run(16'hFFFF, 1'b0, 20'h65535, 1'b0);
        run(16'hFFF6, 1'b1, 20'h00010, 1'b1);
        run(16'h8000, 1'b1, 20'h32768, 1'b1);
        run(16'h0000, 1'b1, 20'h00000, 1'b0);

        // start pulsed again while busy must be ignored
        data  = 16'h0064;
        sm    = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        data  = 16'h0001;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(bn, c1, ok);
        if (ok) check("busy_start_bcd", 32'(bcd), 32'h00100);
        count_dones(25, n);
        check("busy_start_single", 32'(n), 32'd0);
        tick(1);

        // back-to-back with start held high
        data  = 16'h0009;
        start = 1'b1;
        tick(1);
        data = 16'h000A;
        wait_done(bn, c1, ok);
        if (ok) check("b2b_bcd0", 32'(bcd), 32'h00009);
        tick(1);
        data = 16'h03E7;
        wait_done(bn, c2, ok);
        if (ok) begin
            check("b2b_bcd1", 32'(bcd), 32'h00010);
            check("b2b_gap1", 32'(c2 - c1), 32'd17);
        end
        tick(1);
        start = 1'b0;
        wait_done(bn, c3, ok);
        if (ok) begin
            check("b2b_bcd2", 32'(bcd), 32'h00999);
            check("b2b_gap2", 32'(c3 - c2), 32'd17);
        end
        tick(2);

        // reset in the middle of a conversion
        data  = 16'h1234;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_bcd",  32'(bcd),  32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        tick(2);
        rst_n = 1'b1;
        count_dones(25, n);
        check("mid_rst_no_done", 32'(n), 32'd0);
        tick(1);
        run(16'h1234, 1'b0, 20'h04660, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
